sprite_vram_writer: RTL and testbench
=====================================

Name: sprite_vram_writer

Overview:
Write-side master for the 8-bit, 13-bit-address sprite VRAM (8 sprites × 32×32 pixels, palette-indexed) that the SVGA pixel path reads. It accepts pixel-write, sprite-fill and clear-all commands over a valid/ready handshake and drives the VRAM write port. All writes are optionally gated to the display blanking interval so the live sprite read path never observes a partially updated sprite mid-scan.

Parameters:
SPRITE_SIZE, 32, sprite edge in pixels (power of two; x/y fields are log2 wide)
SPRITE_COUNT, 8, sprites held in VRAM
ADDR_WIDTH, 13, VRAM address width = log2(SPRITE_SIZE²·SPRITE_COUNT)
DATA_WIDTH, 8, palette index width
BLANK_ONLY, 1, 1 = issue writes only while video_enable=0; 0 = write any cycle

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous reset, active-low (asserted at 0)
video_enable  in  1  active-display flag from SVGA_sync; writes stall while 1 if BLANK_ONLY=1
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  0=WRITE_PIXEL, 1=FILL_SPRITE, 2=CLEAR_ALL, 3=reserved (accepted, no-op)
cmd_sprite  in  3  target sprite index
cmd_x  in  5  pixel column within sprite
cmd_y  in  5  pixel row within sprite
cmd_colour  in  8  palette index to write
mem_addr  out  13  VRAM address
mem_write  out  1  VRAM write strobe (one word per cycle when 1)
mem_data  out  8  VRAM write data
busy  out  1  command in progress
done  out  1  one-cycle pulse after the last write of a command

Behaviour:
- Reset (reset=0, async): state=IDLE, cmd_ready=0 until the first clk after release, then 1; mem_write=0, mem_addr=0, mem_data=0, busy=0, done=0, counter=0.
- Handshake: transfer on posedge clk when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE (not during DONE). Command fields are latched at transfer; later input changes are ignored.
- Address mapping: addr = {sprite, y, x} = sprite·1024 + y·32 + x; no multipliers, pure concatenation.
- FSM: IDLE -> (accept) -> WRITE -> DONE -> IDLE.
  - WRITE_PIXEL: single write of cmd_colour at {sprite,y,x}.
  - FILL_SPRITE: 1024 writes, addr {sprite, cnt[9:0]}, cnt 0..1023 ascending.
  - CLEAR_ALL: 8192 writes of data 0 (cmd_colour ignored), addr cnt[12:0] 0..8191.
  - reserved op: WRITE skipped; goes directly to DONE (done still pulses).
- Write gate: en = !BLANK_ONLY || !video_enable. In WRITE, mem_write = en (registered alongside addr/data). Counter advances only on cycles with mem_write=1; when en=0, mem_write=0 and addr/data hold.
- Latency: accept at edge N; first mem_write=1 visible after edge N+1 (if en); for WRITE_PIXEL with en continuously 1, done=1 after edge N+2. FILL_SPRITE unstalled: 1024 write cycles, done one cycle after the last.
- Last write: when cnt == terminal (0, 1023 or 8191) with mem_write, next state DONE; counter wraps only by reset to 0 on entry to WRITE — never overruns into a neighbouring sprite.
- busy=1 from the accept edge through the DONE cycle; done=1 only in DONE; mem_write=0 outside WRITE.
- video_enable toggling mid-fill: stall/resume with no skipped or duplicated address.
- Reset mid-command: command is abandoned immediately and mem_write drops asynchronously; no completion pulse.

Decomposition:
- Shared package sprite_vram_pkg: SPRITE_SIZE, SPRITE_COUNT, ADDR_WIDTH, DATA_WIDTH, op encodings (OP_WRITE_PIXEL/OP_FILL_SPRITE/OP_CLEAR_ALL), FSM state encoding; both the display reader and this writer import it.
- One natural sub-module: vram_addr_counter (loadable base, terminal-count compare, enable-gated increment, last flag).

Test Plan:
- Release reset, BLANK_ONLY=1, video_enable=0, WRITE_PIXEL sprite=4,x=3,y=2,colour=0xA5 -> exactly one mem_write with addr=0x1043, data=0xA5; done pulses 2 cycles after accept; cmd_ready back to 1.
- FILL_SPRITE sprite=7, colour=0x1F, video_enable=0 -> 1024 consecutive writes, addr 0x1C00..0x1FFF ascending, data 0x1F, no write outside range, single done pulse.
- FILL_SPRITE sprite=0 with video_enable toggling 1 for 5 cycles every 20 -> mem_write=0 exactly on video_enable=1 cycles; address sequence 0x0000..0x03FF gap-free and duplicate-free.
- CLEAR_ALL with cmd_colour=0xFF -> 8192 writes, data 0, addr 0..0x1FFF; busy held throughout; cmd_valid asserted during busy is not accepted (cmd_ready=0).
- Reset asserted at write #300 of FILL_SPRITE sprite=2 -> mem_write=0 immediately (before next edge), no done pulse, busy=0; new WRITE_PIXEL after release proceeds normally.
- BLANK_ONLY=0, video_enable=1, cmd_op=3 -> no mem_write, done pulses one cycle after accept.

Source files
------------

// File: rtl/sprite_vram_pkg.sv
// Shared definitions for the sprite VRAM: geometry, address helper, command
// op encodings and the writer FSM state encoding.
package sprite_vram_pkg;
    localparam int SPRITE_SIZE  = 32;
    localparam int SPRITE_COUNT = 8;
    localparam int XY_WIDTH     = $clog2(SPRITE_SIZE);
    localparam int SPRITE_WIDTH = $clog2(SPRITE_COUNT);
    localparam int ADDR_WIDTH   = SPRITE_WIDTH + 2 * XY_WIDTH;
    localparam int DATA_WIDTH   = 8;

    localparam logic [ADDR_WIDTH-1:0] FILL_LAST  = ADDR_WIDTH'(SPRITE_SIZE * SPRITE_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = ADDR_WIDTH'(SPRITE_SIZE * SPRITE_SIZE * SPRITE_COUNT - 1);

    typedef enum logic [1:0] {
        OP_WRITE_PIXEL = 2'd0,
        OP_FILL_SPRITE = 2'd1,
        OP_CLEAR_ALL   = 2'd2,
        OP_RESERVED    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Sprite-major layout: pure concatenation, so no multiplier in either path.
    function automatic logic [ADDR_WIDTH-1:0] sprite_addr(
        input logic [SPRITE_WIDTH-1:0] sprite,
        input logic [XY_WIDTH-1:0]     y,
        input logic [XY_WIDTH-1:0]     x
    );
        return {sprite, y, x};
    endfunction
endpackage

// File: rtl/vram_addr_counter.sv
// Address walker for the VRAM writer: loadable base, ascending offset that
// stops at a loaded terminal count, and a last flag at the terminal value.
module vram_addr_counter
    import sprite_vram_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] terminal,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] term_q;
    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
            term_q <= '0;
            cnt    <= '0;
        end else if (load) begin
            base_q <= base;
            term_q <= terminal;
            cnt    <= '0;
        end else if (step && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Base has zero low bits wherever the offset can be non-zero, so OR suffices.
    assign last = (cnt == term_q);
    assign addr = base_q | cnt;
endmodule

// File: rtl/sprite_vram_writer.sv
// Sprite VRAM write master: pixel/fill/clear commands over valid/ready,
// with writes optionally held off until the display is blanked.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready=1
// ST_WRITE | issuing VRAM writes (stalls while the write gate is closed)
// ST_DONE  | one-cycle completion, done=1
module sprite_vram_writer
    import sprite_vram_pkg::*;
#(
    parameter bit BLANK_ONLY = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    video_enable,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [SPRITE_WIDTH-1:0] cmd_sprite,
    input  logic [XY_WIDTH-1:0]     cmd_x,
    input  logic [XY_WIDTH-1:0]     cmd_y,
    input  logic [DATA_WIDTH-1:0]   cmd_colour,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_data,
    output logic                    busy,
    output logic                    done
);
    state_e                  state;
    op_e                     op_q;
    logic [DATA_WIDTH-1:0]   colour_q;
    logic                    last_issued;
    logic                    accept;
    logic                    en;
    logic                    finishing;
    logic [ADDR_WIDTH-1:0]   ld_base;
    logic [ADDR_WIDTH-1:0]   ld_term;
    logic [ADDR_WIDTH-1:0]   ctr_addr;
    logic                    ctr_last;

    assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign en        = !BLANK_ONLY || !video_enable;
    // Leave WRITE only once the final write has actually been presented.
    assign finishing = (state == ST_WRITE) && ((mem_write && last_issued) || (op_q == OP_RESERVED));

    always_comb begin
        ld_base = '0;
        ld_term = '0;
        case (op_e'(cmd_op))
            OP_WRITE_PIXEL: ld_base = sprite_addr(cmd_sprite, cmd_y, cmd_x);
            OP_FILL_SPRITE: begin
                ld_base = sprite_addr(cmd_sprite, '0, '0);
                ld_term = FILL_LAST;
            end
            OP_CLEAR_ALL:   ld_term = CLEAR_LAST;
            default:        ;
        endcase
    end

    vram_addr_counter u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .base     (ld_base),
        .terminal (ld_term),
        .step     ((state == ST_WRITE) && !finishing && en),
        .addr     (ctr_addr),
        .last     (ctr_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            op_q        <= OP_WRITE_PIXEL;
            colour_q    <= '0;
            last_issued <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done      <= 1'b0;
                    mem_write <= 1'b0;
                    if (accept) begin
                        state       <= ST_WRITE;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        op_q        <= op_e'(cmd_op);
                        colour_q    <= (op_e'(cmd_op) == OP_CLEAR_ALL) ? '0 : cmd_colour;
                        last_issued <= 1'b0;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (finishing) begin
                        state     <= ST_DONE;
                        mem_write <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        mem_write <= en;
                        if (en) begin
                            mem_addr    <= ctr_addr;
                            mem_data    <= colour_q;
                            last_issued <= ctr_last;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_vram_writer.sv
// Directed bench for sprite_vram_writer: a gated (BLANK_ONLY=1) instance and an
// ungated (BLANK_ONLY=0) instance sharing command fields.
module tb_sprite_vram_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic        video_enable;
    logic        cmd_valid, cmd_valid0;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_sprite;
    logic [4:0]  cmd_x, cmd_y;
    logic [7:0]  cmd_colour;
    logic        cmd_ready, mem_write, busy, done;
    logic [12:0] mem_addr;
    logic [7:0]  mem_data;
    logic        ready0, mem_write0, busy0, done0;
    logic [12:0] mem_addr0;
    logic [7:0]  mem_data0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    sprite_vram_writer #(.BLANK_ONLY(1'b1)) dut (
        .clk(clk), .reset(reset), .video_enable(video_enable),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sprite(cmd_sprite), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_colour(cmd_colour),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_data(mem_data),
        .busy(busy), .done(done)
    );

    sprite_vram_writer #(.BLANK_ONLY(1'b0)) dut0 (
        .clk(clk), .reset(reset), .video_enable(video_enable),
        .cmd_valid(cmd_valid0), .cmd_ready(ready0), .cmd_op(cmd_op),
        .cmd_sprite(cmd_sprite), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_colour(cmd_colour),
        .mem_addr(mem_addr0), .mem_write(mem_write0), .mem_data(mem_data0),
        .busy(busy0), .done(done0)
    );

    // Call on a negedge; returns #1 after the accepting posedge with fields scrambled.
    task automatic send(input bit sel, input logic [1:0] op, input logic [2:0] spr,
                        input logic [4:0] x, input logic [4:0] y, input logic [7:0] col);
        int n;
        n = 0;
        while (((sel ? ready0 : cmd_ready) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL send_ready: cmd_ready=%b expected 1", sel ? ready0 : cmd_ready);
        end
        cmd_op = op; cmd_sprite = spr; cmd_x = x; cmd_y = y; cmd_colour = col;
        if (sel) cmd_valid0 = 1'b1;
        else cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_valid0 = 1'b0;
        cmd_sprite = ~spr; cmd_x = ~x; cmd_y = ~y; cmd_colour = ~col;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #3;
        total++; if ({cmd_ready, mem_write, busy, done} !== 4'b0000) begin bad++;
            $display("FAIL reset_flags: ready/write/busy/done=%b expected 0000", {cmd_ready, mem_write, busy, done}); end
        total++; if (mem_addr !== 13'h0 || mem_data !== 8'h0) begin bad++;
            $display("FAIL reset_bus: addr=%h data=%h expected 0000/00", mem_addr, mem_data); end
        repeat (2) @(negedge clk);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_held_ready: got %b expected 0", cmd_ready); end
        reset = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL release_ready: got %b expected 0", cmd_ready); end
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL first_clk_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_pixel;
        video_enable = 1'b0;
        send(1'b0, 2'd0, 3'd4, 5'd3, 5'd2, 8'hA5);
        @(negedge clk);
        total++; if ({busy, mem_write, cmd_ready, done} !== 4'b1000) begin bad++;
            $display("FAIL pixel_accept: busy/write/ready/done=%b expected 1000", {busy, mem_write, cmd_ready, done}); end
        @(negedge clk);
        total++; if (mem_write !== 1'b1 || mem_addr !== 13'h1043 || mem_data !== 8'hA5 || done !== 1'b0) begin bad++;
            $display("FAIL pixel_write: we=%b addr=%h data=%h done=%b expected 1 1043 a5 0", mem_write, mem_addr, mem_data, done); end
        @(negedge clk);
        total++; if ({mem_write, done, busy} !== 3'b011) begin bad++;
            $display("FAIL pixel_done: write/done/busy=%b expected 011", {mem_write, done, busy}); end
        @(negedge clk);
        total++; if ({done, busy, cmd_ready} !== 3'b001) begin bad++;
            $display("FAIL pixel_idle: done/busy/ready=%b expected 001", {done, busy, cmd_ready}); end
    endtask

    task automatic test_fill;
        int k, cyc, first_wr, last_wr, done_cyc, dones;
        k = 0; cyc = 0; first_wr = -1; last_wr = -1; done_cyc = -1; dones = 0;
        video_enable = 1'b0;
        send(1'b0, 2'd1, 3'd7, 5'd9, 5'd9, 8'h1F);
        while (dones == 0 && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            if (mem_write === 1'b1) begin
                total++; if (mem_addr !== 13'h1C00 + k[12:0] || mem_data !== 8'h1F) begin bad++;
                    $display("FAIL fill_word: addr=%h data=%h expected %h 1f", mem_addr, mem_data, 13'h1C00 + k[12:0]); end
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                k++;
            end
            if (done === 1'b1) begin dones++; done_cyc = cyc; end
        end
        total++; if (k != 1024) begin bad++; $display("FAIL fill_count: got %0d expected 1024", k); end
        total++; if (first_wr != 2 || last_wr != 1025) begin bad++;
            $display("FAIL fill_span: cycles %0d..%0d expected 2..1025", first_wr, last_wr); end
        total++; if (done_cyc != 1026) begin bad++; $display("FAIL fill_done_cycle: got %0d expected 1026", done_cyc); end
        @(negedge clk);
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL fill_single_done: done/busy=%b expected 00", {done, busy}); end
    endtask

    task automatic test_stall;
        int k, cyc;
        logic prev_ve, exp_we, seen;
        k = 0; cyc = 0; prev_ve = 1'b0; seen = 1'b0;
        video_enable = 1'b0;
        send(1'b0, 2'd1, 3'd0, 5'd1, 5'd1, 8'h66);
        while (!seen && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc >= 2) begin
                exp_we = !prev_ve && (k < 1024);
                total++; if (mem_write !== exp_we) begin bad++;
                    $display("FAIL stall_gate: cyc=%0d mem_write=%b expected %b", cyc, mem_write, exp_we); end
            end
            if (mem_write === 1'b1) begin
                total++; if (mem_addr !== k[12:0] || mem_data !== 8'h66) begin bad++;
                    $display("FAIL stall_addr: addr=%h data=%h expected %h 66", mem_addr, mem_data, k[12:0]); end
                k++;
            end
            if (done === 1'b1) seen = 1'b1;
            video_enable = ((cyc % 20) >= 15);
            prev_ve = video_enable;
        end
        video_enable = 1'b0;
        total++; if (k != 1024 || !seen) begin bad++; $display("FAIL stall_count: writes=%0d done=%b expected 1024 1", k, seen); end
        @(negedge clk);
    endtask

    task automatic test_clear;
        int k, cyc;
        logic seen;
        k = 0; cyc = 0; seen = 1'b0;
        video_enable = 1'b0;
        send(1'b0, 2'd2, 3'd5, 5'd5, 5'd5, 8'hFF);
        cmd_op = 2'd0;
        cmd_valid = 1'b1;
        while (!seen && cyc < 9000) begin
            @(negedge clk);
            cyc++;
            if (mem_write === 1'b1) begin
                total++; if (mem_addr !== k[12:0] || mem_data !== 8'h00) begin bad++;
                    $display("FAIL clear_word: addr=%h data=%h expected %h 00", mem_addr, mem_data, k[12:0]); end
                k++;
            end
            total++; if ({busy, cmd_ready} !== 2'b10) begin bad++;
                $display("FAIL clear_busy: busy/ready=%b expected 10", {busy, cmd_ready}); end
            if (done === 1'b1) begin seen = 1'b1; cmd_valid = 1'b0; end
        end
        cmd_valid = 1'b0;
        total++; if (k != 8192 || !seen) begin bad++; $display("FAIL clear_count: writes=%0d done=%b expected 8192 1", k, seen); end
        @(negedge clk);
        total++; if ({busy, cmd_ready, done} !== 3'b010) begin bad++;
            $display("FAIL clear_idle: busy/ready/done=%b expected 010", {busy, cmd_ready, done}); end
        @(negedge clk);
        total++; if ({busy, mem_write} !== 2'b00) begin bad++;
            $display("FAIL clear_no_extra: busy/write=%b expected 00", {busy, mem_write}); end
    endtask

    task automatic test_blank_stall;
        video_enable = 1'b1;
        send(1'b0, 2'd0, 3'd6, 5'd1, 5'd1, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if ({mem_write, done, busy} !== 3'b001) begin bad++;
                $display("FAIL blank_hold: write/done/busy=%b expected 001", {mem_write, done, busy}); end
        end
        video_enable = 1'b0;
        @(negedge clk);
        total++; if (mem_write !== 1'b1 || mem_addr !== 13'h1821 || mem_data !== 8'h5A) begin bad++;
            $display("FAIL blank_release: we=%b addr=%h data=%h expected 1 1821 5a", mem_write, mem_addr, mem_data); end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL blank_done: got %b expected 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int k, cyc;
        logic any_done;
        k = 0; cyc = 0; any_done = 1'b0;
        video_enable = 1'b0;
        send(1'b0, 2'd1, 3'd2, 5'd0, 5'd0, 8'h77);
        while (k < 300 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (mem_write === 1'b1) k++;
        end
        total++; if (k != 300 || mem_addr !== 13'h092B) begin bad++;
            $display("FAIL midreset_pos: writes=%0d addr=%h expected 300 092b", k, mem_addr); end
        reset = 1'b0;
        #1;
        total++; if ({mem_write, busy, done, cmd_ready} !== 4'b0000) begin bad++;
            $display("FAIL midreset_async: write/busy/done/ready=%b expected 0000", {mem_write, busy, done, cmd_ready}); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1 || mem_write === 1'b1) any_done = 1'b1;
        end
        total++; if (any_done !== 1'b0 || {busy, cmd_ready} !== 2'b01) begin bad++;
            $display("FAIL midreset_quiet: stray=%b busy/ready=%b expected 0 01", any_done, {busy, cmd_ready}); end
        send(1'b0, 2'd0, 3'd1, 5'd31, 5'd31, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        total++; if (mem_write !== 1'b1 || mem_addr !== 13'h07FF || mem_data !== 8'h3C) begin bad++;
            $display("FAIL midreset_pixel: we=%b addr=%h data=%h expected 1 07ff 3c", mem_write, mem_addr, mem_data); end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL midreset_done: got %b expected 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reserved;
        video_enable = 1'b1;
        send(1'b1, 2'd3, 3'd1, 5'd1, 5'd1, 8'h11);
        @(negedge clk);
        total++; if ({busy0, mem_write0, done0} !== 3'b100) begin bad++;
            $display("FAIL reserved_accept: busy/write/done=%b expected 100", {busy0, mem_write0, done0}); end
        @(negedge clk);
        total++; if ({mem_write0, done0} !== 2'b01) begin bad++;
            $display("FAIL reserved_done: write/done=%b expected 01", {mem_write0, done0}); end
        @(negedge clk);
        total++; if ({done0, busy0, ready0, mem_write0} !== 4'b0010) begin bad++;
            $display("FAIL reserved_idle: done/busy/ready/write=%b expected 0010", {done0, busy0, ready0, mem_write0}); end
    endtask

    task automatic test_anytime;
        video_enable = 1'b1;
        send(1'b1, 2'd0, 3'd3, 5'd5, 5'd6, 8'hC3);
        @(negedge clk);
        @(negedge clk);
        total++; if (mem_write0 !== 1'b1 || mem_addr0 !== 13'h0CC5 || mem_data0 !== 8'hC3) begin bad++;
            $display("FAIL anytime_write: we=%b addr=%h data=%h expected 1 0cc5 c3", mem_write0, mem_addr0, mem_data0); end
        @(negedge clk);
        total++; if (done0 !== 1'b1) begin bad++; $display("FAIL anytime_done: got %b expected 1", done0); end
        total++; if ({busy, mem_write} !== 2'b00) begin bad++;
            $display("FAIL gated_untouched: busy/write=%b expected 00", {busy, mem_write}); end
        video_enable = 1'b0;
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_valid0 = 1'b0; video_enable = 1'b0;
        cmd_op = 2'd0; cmd_sprite = 3'd0; cmd_x = 5'd0; cmd_y = 5'd0; cmd_colour = 8'd0;
        test_reset;
        test_pixel;
        test_fill;
        test_stall;
        test_clear;
        test_blank_stall;
        test_reset_mid;
        test_reserved;
        test_anytime;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
